pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the pipelined MIPS core. It holds the fetch address, selects the next PC from sequential, branch/jump, exception-entry and eret sources, and honours pipeline stalls. A redirect that arrives while fetch is stalled is buffered, not dropped. The block sits at the head of the F stage and drives the instruction-memory address and F/D pipeline register.

## Interface
- WIDTH, 32, PC/address width in bits (≥ 16)
- RESET_PC, 32'h0000_3000, PC value after reset
- EXC_VECTOR, 32'h0000_4180, exception handler entry address
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address
- IMEM_TOP, 32'h0000_6FFF, highest legal fetch address (inclusive)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- en  input  1  advance enable; 0 = F stage stalled
- redir_valid  input  1  branch/jump redirect request from D stage
- redir_target  input  WIDTH  redirect destination
- exc_req  input  1  exception entry request
- eret_req  input  1  return-from-exception request
- epc  input  WIDTH  return address for eret
- pc  output  WIDTH  current fetch address (registered)
- pc_plus4  output  WIDTH  pc + 4, combinational
- pend_valid  output  1  a buffered redirect is waiting
- fetch_adel  output  1  current pc is misaligned or out of range

## Operation
- Next-PC priority, highest first: reset → RESET_PC; exc_req → EXC_VECTOR; eret_req → epc; pending redirect or redir_valid → target; otherwise pc_plus4.
- exc_req and eret_req update pc even when en = 0. Both also clear the pending buffer.
- All other updates apply only when en = 1. When en = 0 and no exc/eret is present, pc holds.
- Two states: IDLE and PEND.
  - IDLE, redir_valid=1, en=0 → latch redir_target, go to PEND.
  - IDLE, redir_valid=1, en=1 → pc ← redir_target, stay in IDLE.
  - PEND, en=0, redir_valid=1 → overwrite the buffer with the new target.
  - PEND, en=1 → pc ← redir_valid ? redir_target : buffered target, go to IDLE.
  - Any exc_req or eret_req → IDLE.
- pend_valid = (state == PEND).
- pc_plus4 = pc + 4, truncated to WIDTH bits; it wraps at 2^WIDTH with no flag.
- fetch_adel = (pc[1:0] != 0) | (pc < IMEM_BASE) | (pc > IMEM_TOP). Comparisons are unsigned. fetch_adel does not alter PC flow; the CP0 logic consumes it.

## Timing
- Reset values: pc = RESET_PC, pend_valid = 0, state IDLE. fetch_adel reflects RESET_PC, so it is 0 at the defaults.
- Latency: a request sampled at edge N is visible on pc after edge N. A buffered redirect lands on the first edge with en = 1.
- reset during PEND discards the buffered target.
- exc_req and eret_req asserted together: exc_req wins.
- exc_req with en = 0: pc = EXC_VECTOR after the edge, and the stall does not delay it.

## Configuration
- PC_GEN_EXC_EN defined: exc_req, eret_req, epc and fetch_adel behave as described.
- PC_GEN_EXC_EN undefined:
  - exc_req, eret_req and epc are ignored.
  - fetch_adel is tied to 0 and the range/alignment logic is not synthesised.
  - Priority reduces to reset → redirect → pc_plus4.

## Test plan
- Reset then 3 cycles with en=1 → pc 0x3000, 0x3004, 0x3008, 0x300C. pend_valid=0 and fetch_adel=0 throughout.
- redir_valid=1, target 0x3100, with en=0 for 2 cycles, then en=1 → pc holds while pend_valid=1. After the first enabled edge, pc=0x3100 and pend_valid=0.
- While in PEND with target 0x3100, a new redirect to 0x3200 arrives with en still 0, then en=1 → pc=0x3200.
- With PC_GEN_EXC_EN: exc_req=1 and eret_req=1 with en=0 → pc=0x4180 next cycle, pend_valid=0. Then eret_req=1 with epc=0x3010 → pc=0x3010.
- redir_target 0x3002 → fetch_adel=1 the cycle after the jump. redir_target 0x7000 → fetch_adel=1. redir_target 0x6FFC → fetch_adel=0.
- reset asserted while pend_valid=1 → pc=0x3000 and pend_valid=0 after the edge. With PC_GEN_EXC_EN undefined, exc_req=1 has no effect on pc.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator at the head of the F stage: picks the next fetch address and buffers redirects that arrive while fetch is stalled.
// Optional exception/eret entry and fetch address-error detection are enabled by defining PC_GEN_EXC_EN.
module pc_gen #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [WIDTH-1:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [WIDTH-1:0] IMEM_TOP   = 32'h0000_6FFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             pend_valid,
  output logic             fetch_adel
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pend_target;
  logic [WIDTH-1:0] pend_target_next;
  logic [WIDTH-1:0] pc_next;
  logic             exc_take;
  logic             eret_take;

`ifdef PC_GEN_EXC_EN
  // exc_req outranks eret_req when both arrive together.
  assign exc_take  = exc_req;
  assign eret_take = eret_req & ~exc_req;
`else
  assign exc_take  = 1'b0;
  assign eret_take = 1'b0;
  logic unused_exc;
  assign unused_exc = ^{exc_req, eret_req, epc, EXC_VECTOR, IMEM_BASE, IMEM_TOP};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pend_target <= RESET_PC;
      pc          <= RESET_PC;
    end else begin
      state       <= state_next;
      pend_target <= pend_target_next;
      pc          <= pc_next;
    end
  end

  // Exception entry and eret bypass the stall; everything else waits for en.
  always_comb begin
    state_next       = state;
    pend_target_next = pend_target;
    pc_next          = pc;
    if (exc_take) begin
      state_next = IDLE;
      pc_next    = EXC_VECTOR;
    end else if (eret_take) begin
      state_next = IDLE;
      pc_next    = epc;
    end else begin
      case (state)
        IDLE: begin
          if (redir_valid && !en) begin
            state_next       = PEND;
            pend_target_next = redir_target;
          end
        end
        PEND: begin
          if (en) begin
            state_next = IDLE;
          end else if (redir_valid) begin
            pend_target_next = redir_target;
          end
        end
        default: state_next = IDLE;
      endcase
      if (en) begin
        if (redir_valid) begin
          pc_next = redir_target;
        end else if (state == PEND) begin
          pc_next = pend_target;
        end else begin
          pc_next = pc_plus4;
        end
      end
    end
  end

  always_comb begin
    pc_plus4   = pc + {{(WIDTH-3){1'b0}}, 3'd4};
    pend_valid = (state == PEND);
`ifdef PC_GEN_EXC_EN
    fetch_adel = (pc[1:0] != 2'b00) | (pc < IMEM_BASE) | (pc > IMEM_TOP);
`else
    fetch_adel = 1'b0;
`endif
  end

endmodule
